// File: rtl/key_step_pulser.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release pulses,
// auto-repeat step pulses and an 8-bit step tally, all on CLOCK_50.
module key_step_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_N,
    input  logic       CLR_CNT,
    output logic       PRESSED,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic       STEP,
    output logic [7:0] STEP_COUNT
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY);
    localparam logic [RepW-1:0] RepRate  = RepW'(REPEAT_RATE);

    typedef enum logic [1:0] {StIdle, StPressChk, StHeld, StRelChk} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, key_s_q;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_first_q, rep_first_d;
    logic            pressed_q, press_pulse_q, release_pulse_q, step_q;
    logic [7:0]      step_count_q;
    logic            pressed_d, rep_fire_d;

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!key_s_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StHeld;
                    end else begin
                        state_d  = StPressChk;
                        db_cnt_d = DbW'(1);
                    end
                end
            end
            StPressChk: begin
                if (key_s_q) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    state_d  = StHeld;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            StHeld: begin
                if (key_s_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StRelChk;
                        db_cnt_d = DbW'(1);
                    end
                end
            end
            StRelChk: begin
                if (!key_s_q) begin
                    state_d  = StHeld;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                db_cnt_d = '0;
            end
        endcase
    end

    // rep_cnt counts HELD cycles since entry or since the last repeat; it is
    // frozen in REL_CHK so a rejected release resumes the cadence unchanged.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        if (state_q == StHeld) begin
            if (rep_cnt_q == (rep_first_q ? RepRate : RepDelay)) begin
                rep_cnt_d   = RepW'(1);
                rep_first_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
        end
        if (state_d == StIdle || state_d == StPressChk) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end
        pressed_d  = (state_d == StHeld) || (state_d == StRelChk);
        rep_fire_d = REPEAT_EN && (state_d == StHeld) &&
                     (rep_cnt_d == (rep_first_d ? RepRate : RepDelay));
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q         <= 1'b1;
            key_s_q         <= 1'b1;
            state_q         <= StIdle;
            db_cnt_q        <= '0;
            rep_cnt_q       <= '0;
            rep_first_q     <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            step_q          <= 1'b0;
            step_count_q    <= 8'd0;
        end else begin
            sync1_q         <= KEY_N;
            key_s_q         <= sync1_q;
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            rep_cnt_q       <= rep_cnt_d;
            rep_first_q     <= rep_first_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= pressed_d && !pressed_q;
            release_pulse_q <= !pressed_d && pressed_q;
            step_q          <= (pressed_d && !pressed_q) || rep_fire_d;
            step_count_q    <= CLR_CNT ? 8'd0 : step_count_q + 8'(step_q);
        end
    end

    assign PRESSED       = pressed_q;
    assign PRESS_PULSE   = press_pulse_q;
    assign RELEASE_PULSE = release_pulse_q;
    assign STEP          = step_q;
    assign STEP_COUNT    = step_count_q;

endmodule

// File: tb/tb_key_step_pulser.sv
// Bench for key_step_pulser: two instances (no-repeat D=4, repeat D=2/10/3) checked
// against a run-length/held-index model, plus directed literal checks.
module tb_key_step_pulser;

    logic       CLOCK_50;
    logic       RESET;
    logic       KEY_N;
    logic       CLR_CNT;
    logic [1:0] pressed, press_pulse, release_pulse, step;
    logic [7:0] step_count [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;
    int e;

    key_step_pulser #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) u_dut0 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N), .CLR_CNT(CLR_CNT),
        .PRESSED(pressed[0]), .PRESS_PULSE(press_pulse[0]),
        .RELEASE_PULSE(release_pulse[0]), .STEP(step[0]), .STEP_COUNT(step_count[0])
    );

    key_step_pulser #(
        .DEBOUNCE_CYCLES(2), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) u_dut1 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N), .CLR_CNT(CLR_CNT),
        .PRESSED(pressed[1]), .PRESS_PULSE(press_pulse[1]),
        .RELEASE_PULSE(release_pulse[1]), .STEP(step[1]), .STEP_COUNT(step_count[1])
    );

    initial begin
        CLOCK_50 = 0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Model: lvl is the accepted level, run the length of the current streak of
    // samples disagreeing with it; held_idx counts stable-held cycles since press.
    bit         m_s1 [2], m_s2 [2], m_lvl [2], m_pp [2], m_rp [2], m_st [2];
    int         m_run [2], m_held_idx [2];
    logic [7:0] m_cnt [2];

    task automatic model_edge(input int i, input int d, input bit ren, input int rd,
                              input int rr);
        bit ks, was_pressed, was_held, rep;
        if (RESET) begin
            m_s1[i] = 1; m_s2[i] = 1; m_lvl[i] = 0; m_run[i] = 0; m_held_idx[i] = 0;
            m_pp[i] = 0; m_rp[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
            return;
        end
        m_cnt[i] = CLR_CNT ? 8'd0 : m_cnt[i] + 8'(m_st[i]);
        ks = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = KEY_N;
        was_pressed = m_lvl[i];
        was_held = m_lvl[i] && (m_run[i] == 0);
        if ((!ks) != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == d) begin
                m_lvl[i] = !ks;
                m_run[i] = 0;
            end
        end else begin
            m_run[i] = 0;
        end
        if (was_held) m_held_idx[i]++;
        m_pp[i] = m_lvl[i] && !was_pressed;
        m_rp[i] = !m_lvl[i] && was_pressed;
        if (m_pp[i] || !m_lvl[i]) m_held_idx[i] = 0;
        rep = ren && m_lvl[i] && (m_run[i] == 0) && !m_pp[i] && (m_held_idx[i] >= rd) &&
              (((m_held_idx[i] - rd) % rr) == 0);
        m_st[i] = m_pp[i] || rep;
    endtask

    always @(posedge CLOCK_50) begin
        model_edge(0, 4, 1'b0, 10, 3);
        model_edge(1, 2, 1'b1, 10, 3);
    end

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [11:0] got, exp;
                got = {pressed[i], press_pulse[i], release_pulse[i], step[i], step_count[i]};
                exp = {m_lvl[i], m_pp[i], m_rp[i], m_st[i], m_cnt[i]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL model_cmp inst=%0d t=%0t got(pr,pp,rp,st,cnt)=%b %b %b %b %0d exp=%b %b %b %b %0d",
                             i, $time, got[11], got[10], got[9], got[8], got[7:0],
                             exp[11], exp[10], exp[9], exp[8], exp[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        e++;
        @(negedge CLOCK_50);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, seen_hi, nsteps, seg_left;
        bit found;
        KEY_N = 1; RESET = 1; CLR_CNT = 0; e = 0;
        repeat (3) tick();
        cmp_en = 1;
        check("reset_pressed", int'(pressed), 0);
        check("reset_pulses", int'({press_pulse, release_pulse, step}), 0);
        check("reset_count0", int'(step_count[0]), 0);

        // Clean press at edge 0, release from edge 30 with a glitch at edge 32.
        RESET = 0;
        tick();
        KEY_N = 0;
        e = 0;
        n1 = 0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (e >= 4 && e <= 33 && step[1]) n1++;
            case (e)
                4:  check("inst1_press_pulse_e4", int'(press_pulse[1]), 1);
                5:  check("press_not_yet_e5", int'(pressed[0]), 0);
                6:  begin
                    check("pressed_e6", int'(pressed[0]), 1);
                    check("press_pulse_e6", int'(press_pulse[0]), 1);
                    check("step_e6", int'(step[0]), 1);
                end
                7:  begin
                    check("press_pulse_off_e7", int'(press_pulse[0]), 0);
                    check("step_off_e7", int'(step[0]), 0);
                    check("count_e7", int'(step_count[0]), 1);
                end
                13: check("no_repeat_p9", int'(step[1]), 0);
                14: check("first_repeat_p10", int'(step[1]), 1);
                17: check("second_repeat_p13", int'(step[1]), 1);
                34: check("repeat_count_e34", int'(step_count[1]), 8);
                38: begin
                    check("still_pressed_e38", int'(pressed[0]), 1);
                    check("no_release_e38", int'(release_pulse[0]), 0);
                end
                39: begin
                    check("released_e39", int'(pressed[0]), 0);
                    check("release_pulse_e39", int'(release_pulse[0]), 1);
                end
                40: check("release_pulse_off_e40", int'(release_pulse[0]), 0);
                default: ;
            endcase
            KEY_N = (e < 30) ? 1'b0 : ((e == 32) ? 1'b0 : 1'b1);
        end
        check("inst1_steps_in_hold", n1, 8);

        // Bounce pattern must never be accepted by the D=4 instance.
        seen_hi = 0;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] pat;
            pat = 8'b1110_0100;
            KEY_N = (k < 8) ? pat[k] : 1'b1;
            tick();
            if (pressed[0] || step[0]) seen_hi++;
        end
        check("bounce_rejected", seen_hi, 0);
        check("bounce_count", int'(step_count[0]), 1);

        // Wrap: clear, then hold until 256 steps have been seen on inst1.
        CLR_CNT = 1;
        tick();
        CLR_CNT = 0;
        KEY_N = 0;
        nsteps = 0;
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            if (step[1]) nsteps++;
            if (nsteps == 256) begin
                found = 1;
                break;
            end
            tick();
        end
        check("wrap_reached", int'(found), 1);
        tick();
        check("wrap_count_zero", int'(step_count[1]), 0);

        // Clear in the same cycle as a step.
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (step[1]) begin
                found = 1;
                break;
            end
            tick();
        end
        check("step_for_clear_found", int'(found), 1);
        CLR_CNT = 1;
        tick();
        CLR_CNT = 0;
        check("clear_beats_step", int'(step_count[1]), 0);

        // Reset while held.
        check("held_before_reset", int'(pressed[0]), 1);
        RESET = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("reset_held_outputs",
                  int'({pressed[0], press_pulse[0], release_pulse[0], step[0]}), 0);
            check("reset_held_count", int'(step_count[0]), 0);
        end
        RESET = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) check("repress_not_yet", int'(pressed[0]), 0);
            if (k == 6) check("repress_e6", int'(pressed[0]), 1);
            if (k == 7) check("repress_count", int'(step_count[0]), 1);
        end

        // Random phase, checked by the model every cycle.
        seg_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                KEY_N = 1'($urandom_range(0, 1));
                seg_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                       : $urandom_range(4, 40);
            end
            seg_left--;
            CLR_CNT = ($urandom_range(0, 63) == 0);
            RESET = ($urandom_range(0, 499) == 0);
            tick();
        end
        RESET = 0;
        CLR_CNT = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
